uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART_TX serializer between NUM_REQ byte producers using round-robin arbitration.
- Latches the winner's byte and parity configuration, then issues a one-cycle DATA_VALID to the transmitter.
- Tracks the transmitter's busy flag through the whole frame and reports per-requester grant/done plus a start-timeout error.
- Sits between system-side producers (register file, ALU result path) and the UART_TX instance.

Parameters:
- DATA_WIDTH, 8, byte width; must match the UART_TX data_width.
- NUM_REQ, 4, number of requesters; valid range 2..8.
- START_TIMEOUT, 4, max cycles to wait for TX_BUSY to rise after DATA_VALID; valid range 1..15.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- REQ  in  NUM_REQ  per-requester transmit request; level, held until GNT
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- REQ_PAR_EN  in  NUM_REQ  per-requester parity enable
- REQ_PAR_TYPE  in  NUM_REQ  per-requester parity type (0 even, 1 odd)
- GNT  out  NUM_REQ  one-hot, one-cycle pulse: byte accepted
- DONE  out  NUM_REQ  one-hot, one-cycle pulse: frame finished on line
- TX_BUSY  in  1  busy flag from UART_TX
- TX_P_DATA  out  DATA_WIDTH  byte to UART_TX
- TX_DATA_VALID  out  1  load strobe to UART_TX
- TX_PAR_EN  out  1  parity enable to UART_TX
- TX_PAR_TYPE  out  1  parity type to UART_TX
- OWNER  out  clog2(NUM_REQ)  index of the current/last granted requester
- ACTIVE  out  1  high from ISSUE through WAIT_DONE
- TIMEOUT_ERR  out  1  one-cycle pulse: TX_BUSY never rose

Behaviour:
- All outputs are registered.
- Reset values: GNT=0, DONE=0, TX_P_DATA=0, TX_DATA_VALID=0, TX_PAR_EN=0, TX_PAR_TYPE=0, OWNER=0, ACTIVE=0, TIMEOUT_ERR=0. Round-robin pointer resets to 0; state resets to IDLE.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If |REQ and TX_BUSY==0, select winner w as the first asserted REQ at or after the pointer, wrapping modulo NUM_REQ.
  - Latch REQ_DATA[w], REQ_PAR_EN[w] and REQ_PAR_TYPE[w] into TX_P_DATA, TX_PAR_EN and TX_PAR_TYPE.
  - Set OWNER=w and pointer=(w+1) mod NUM_REQ, then go to ISSUE.
  - If TX_BUSY==1, no grant is made; remain in IDLE.
- ISSUE (exactly 1 cycle):
  - TX_DATA_VALID=1, GNT[w]=1, ACTIVE=1.
  - Go to WAIT_BUSY and clear the timeout counter.
  - Latency from REQ sampled in IDLE to GNT/DATA_VALID is 1 cycle.
- WAIT_BUSY:
  - If TX_BUSY==1, go to WAIT_DONE.
  - Else increment the counter. When counter reaches START_TIMEOUT-1 with TX_BUSY still low: pulse TIMEOUT_ERR, drop ACTIVE, return to IDLE. DONE is not pulsed in this case.
- WAIT_DONE:
  - When TX_BUSY==0, pulse DONE[OWNER] for 1 cycle, drop ACTIVE, return to IDLE.
  - A new grant can issue in the cycle after DONE.
- TX_P_DATA, TX_PAR_EN and TX_PAR_TYPE hold stable from ISSUE until the next grant, because UART_TX parity is combinational on P_DATA.
- REQ changes after the winner is latched have no effect on the current frame.
- A requester still asserting REQ after GNT is treated as a new request and is eligible again at the next IDLE, subject to round-robin order.
- Simultaneous requests: strict round-robin; no requester can be starved beyond NUM_REQ-1 frames.
- Reset mid-frame: FSM returns to IDLE immediately and all outputs take their reset values. No DONE or TIMEOUT_ERR is emitted for the aborted frame.
- Timeout counter width: 4 bits.
- OWNER retains its last value when idle.

Decomposition:
- Package uart_arb_pkg: state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3) and the timeout counter width constant.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: REQ vector, pointer.
  - Outputs: one-hot grant, winner index, any-valid.
- All sequencing stays in uart_tx_arbiter.

Test Plan:
- Single request: REQ=4'b0010, REQ_DATA[1]=8'hA5, PAR_EN=1, PAR_TYPE=0; TX_BUSY model rises 1 cycle after DATA_VALID and stays high 11 cycles -> GNT=4'b0010 and TX_DATA_VALID=1 one cycle after REQ, TX_P_DATA=8'hA5, TX_PAR_EN=1, DONE=4'b0010 one cycle after TX_BUSY falls.
- Contention: REQ=4'b1111 held continuously, pointer=0 -> grants in order 0,1,2,3,0; OWNER follows 0,1,2,3,0; each GNT is exactly one cycle.
- Blocked start: TX_BUSY=1 while REQ=4'b0001 -> no GNT and no DATA_VALID until TX_BUSY=0; grant follows 1 cycle later.
- Timeout: TX_BUSY held 0 after ISSUE with START_TIMEOUT=4 -> TIMEOUT_ERR pulses on the 4th WAIT_BUSY cycle, no DONE, ACTIVE=0, a new grant is possible next cycle.
- Reset mid-frame: assert RST during WAIT_DONE -> next cycle all outputs are 0, pointer=0, state IDLE; the next REQ=4'b0100 is granted normally.
- Data stability: change REQ_DATA[0] from 8'h3C to 8'hFF during WAIT_DONE -> TX_P_DATA stays 8'h3C until the next grant.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared constants for the UART transmit arbiter: FSM state encoding and
// start-timeout counter sizing.
package uart_arb_pkg;

  // FSM state encoding (kept as plain constants for legacy compatibility)
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  // Width of the counter that bounds the wait for TX_BUSY to rise
  localparam int TMO_CNT_W = 4;

  typedef logic [1:0]           arb_state_t;
  typedef logic [TMO_CNT_W-1:0] tmo_cnt_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// after ptr, wrapping modulo NUM_REQ, as both a one-hot vector and an index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  // One extra bit so ptr + offset never overflows before the wrap
  localparam int                 SUM_W     = IDX_W + 1;
  localparam logic [SUM_W-1:0]   NUM_REQ_S = SUM_W'(NUM_REQ);

  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] rot_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [SUM_W-1:0] idx_sum;
      // Candidate gi is the requester sitting gi places after the pointer
      assign idx_sum       = {1'b0, ptr} + SUM_W'(gi);
      assign cand_idx[gi]  = (idx_sum >= NUM_REQ_S) ? IDX_W'(idx_sum - NUM_REQ_S)
                                                    : IDX_W'(idx_sum);
      assign rot_req[gi]   = req[cand_idx[gi]];
    end
  endgenerate

  // Scan candidates from farthest to nearest so the nearest asserted one wins
  always_comb begin
    valid  = |req;
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        winner = cand_idx[k];
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign grant[gi] = valid && (winner == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_TX serializer between NUM_REQ byte producers. A round-robin
// winner's byte and parity settings are latched, handed to the transmitter
// with a one-cycle load strobe, and the frame is tracked via TX_BUSY until it
// completes (DONE) or the transmitter never starts (TIMEOUT_ERR).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,   // must match the UART_TX data width
  parameter int NUM_REQ       = 4,   // 2..8
  parameter int START_TIMEOUT = 4    // 1..15
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_PAR_EN,
  input  logic [NUM_REQ-1:0]            REQ_PAR_TYPE,
  output logic [NUM_REQ-1:0]            GNT,
  output logic [NUM_REQ-1:0]            DONE,
  input  logic                          TX_BUSY,
  output logic [DATA_WIDTH-1:0]         TX_P_DATA,
  output logic                          TX_DATA_VALID,
  output logic                          TX_PAR_EN,
  output logic                          TX_PAR_TYPE,
  output logic [$clog2(NUM_REQ)-1:0]    OWNER,
  output logic                          ACTIVE,
  output logic                          TIMEOUT_ERR
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam tmo_cnt_t         TMO_LAST = TMO_CNT_W'(START_TIMEOUT - 1);

  arb_state_t                state_reg;
  logic [IDX_W-1:0]          ptr_reg;
  tmo_cnt_t                  cnt_reg;
  logic [IDX_W-1:0]          owner_reg;
  logic [NUM_REQ-1:0]        gnt_reg;
  logic [NUM_REQ-1:0]        done_reg;
  logic [DATA_WIDTH-1:0]     data_reg;
  logic                      par_en_reg;
  logic                      par_type_reg;
  logic                      dv_reg;
  logic                      active_reg;
  logic                      tmo_reg;

  logic [NUM_REQ-1:0]        pick_grant;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_valid;
  logic [IDX_W-1:0]          ptr_next;
  logic [DATA_WIDTH-1:0]     req_data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]        owner_onehot;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (REQ),
    .ptr    (ptr_reg),
    .grant  (pick_grant),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      // Unpack the flat byte bus and decode the owner for the DONE pulse
      assign req_data_arr[gi] = REQ_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
      assign owner_onehot[gi] = (owner_reg == IDX_W'(gi));
    end
  endgenerate

  // Pointer moves one past the winner so it has lowest priority next round
  assign ptr_next = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);

  // Arbitration / frame-tracking FSM; pulse outputs default low every cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      owner_reg    <= '0;
      gnt_reg      <= '0;
      done_reg     <= '0;
      data_reg     <= '0;
      par_en_reg   <= 1'b0;
      par_type_reg <= 1'b0;
      dv_reg       <= 1'b0;
      active_reg   <= 1'b0;
      tmo_reg      <= 1'b0;
    end else begin
      gnt_reg  <= '0;
      done_reg <= '0;
      dv_reg   <= 1'b0;
      tmo_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Never load the serializer while it is still shifting a frame
          if (pick_valid && !TX_BUSY) begin
            data_reg     <= req_data_arr[pick_idx];
            par_en_reg   <= REQ_PAR_EN[pick_idx];
            par_type_reg <= REQ_PAR_TYPE[pick_idx];
            owner_reg    <= pick_idx;
            ptr_reg      <= ptr_next;
            gnt_reg      <= pick_grant;
            dv_reg       <= 1'b1;
            active_reg   <= 1'b1;
            state_reg    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (TX_BUSY) begin
            state_reg <= WAIT_DONE;
          end else if (cnt_reg == TMO_LAST) begin
            tmo_reg    <= 1'b1;
            active_reg <= 1'b0;
            state_reg  <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + TMO_CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!TX_BUSY) begin
            done_reg   <= owner_onehot;
            active_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign GNT           = gnt_reg;
  assign DONE          = done_reg;
  assign TX_P_DATA     = data_reg;
  assign TX_DATA_VALID = dv_reg;
  assign TX_PAR_EN     = par_en_reg;
  assign TX_PAR_TYPE   = par_type_reg;
  assign OWNER         = owner_reg;
  assign ACTIVE        = active_reg;
  assign TIMEOUT_ERR   = tmo_reg;

endmodule
